hazard_scoreboard: RTL



---
 rtl/hazard_scoreboard.sv | 117 +++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// D-stage hazard controller: tracks {a3, tnew, epc} tokens through E/M/W and
// derives the D-stage stall and rs/rt forward selects from Tuse vs Tnew.

module hazard_src_match #(
   parameter int TW = 2,
   parameter int AW = 5
) (
   input  logic [AW-1:0]         addr,
   input  logic [TW-1:0]         tuse,
   input  logic [2:0][AW-1:0]    stg_a3,    // [0]=E, [1]=M, [2]=W
   input  logic [2:0][TW-1:0]    stg_tnew,
   output logic [1:0]            fwd,
   output logic                  stl
);
   logic          hit;
   logic [1:0]    code;
   logic [TW-1:0] win_tnew;

   // Scan far-to-near so the nearest matching stage overwrites the others.
   always_comb begin
      hit      = 1'b0;
      code     = 2'd0;
      win_tnew = '0;
      if (addr != '0 && tuse != {TW{1'b1}}) begin
         for (int i = 2; i >= 0; i--) begin
            if (stg_a3[i] == addr) begin
               hit      = 1'b1;
               code     = 2'(i + 1);
               win_tnew = stg_tnew[i];
            end
         end
      end
      fwd = (hit && win_tnew == '0) ? code : 2'd0;
      stl = hit && (win_tnew > tuse);
   end
endmodule

module hazard_scoreboard #(
   parameter int TW = 2,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] d_rs,
   input  logic [AW-1:0] d_rt,
   input  logic [TW-1:0] d_tuse_rs,
   input  logic [TW-1:0] d_tuse_rt,
   input  logic [AW-1:0] d_a3,
   input  logic [TW-1:0] d_tnew,
   input  logic          d_epc_wr,
   input  logic          d_eret,
   input  logic          flush,
   output logic          stall,
   output logic [1:0]    fwd_rs,
   output logic [1:0]    fwd_rt
);
   localparam int NUM_SRC = 2;

   typedef struct packed {
      logic [AW-1:0] a3;
      logic [TW-1:0] tnew;
      logic          epc;
   } tok_t;

   tok_t tok_e, tok_m, tok_w;

   function automatic logic [TW-1:0] sat0(input logic [TW-1:0] t);
      return (t == '0) ? '0 : t - TW'(1);
   endfunction

   logic [2:0][AW-1:0]         stg_a3;
   logic [2:0][TW-1:0]         stg_tnew;
   logic [NUM_SRC-1:0][AW-1:0] src_addr;
   logic [NUM_SRC-1:0][TW-1:0] src_tuse;
   logic [NUM_SRC-1:0][1:0]    src_fwd;
   logic [NUM_SRC-1:0]         src_stl;
   logic                       stall_eret;

   assign stg_a3   = {tok_w.a3,   tok_m.a3,   tok_e.a3};
   assign stg_tnew = {tok_w.tnew, tok_m.tnew, tok_e.tnew};
   assign src_addr = {d_rt, d_rs};
   assign src_tuse = {d_tuse_rt, d_tuse_rs};

   for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      hazard_src_match #(.TW(TW), .AW(AW)) u_match (
         .addr     (src_addr[s]),
         .tuse     (src_tuse[s]),
         .stg_a3   (stg_a3),
         .stg_tnew (stg_tnew),
         .fwd      (src_fwd[s]),
         .stl      (src_stl[s])
      );
   end

   // An EPC write already in W is committed, so only E/M block eret.
   assign stall_eret = d_eret & (tok_e.epc | tok_m.epc);
   assign stall      = (|src_stl) | stall_eret;
   assign fwd_rs     = src_fwd[0];
   assign fwd_rt     = src_fwd[1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tok_e <= '0;
         tok_m <= '0;
         tok_w <= '0;
      end else if (flush) begin
         tok_e <= '0;
         tok_m <= '0;
         tok_w <= '0;
      end else begin
         tok_w <= tok_t'{a3: tok_m.a3, tnew: sat0(tok_m.tnew), epc: tok_m.epc};
         tok_m <= tok_t'{a3: tok_e.a3, tnew: sat0(tok_e.tnew), epc: tok_e.epc};
         tok_e <= stall ? tok_t'('0)
                        : tok_t'{a3: d_a3, tnew: d_tnew, epc: d_epc_wr};
      end
   end
endmodule
